// File: rtl/delay_meas_pkg.sv
// Shared definitions for the loop-delay measurement sequencer: FSM state
// encoding, default parameter values and a small limit-clamping helper.
package delay_meas_pkg;

    // Sequencer states (3-bit encoding).
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_PULSE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAPW    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam int CNT_W_DEF    = 16;
    localparam int AVG_LOG2_DEF = 3;
    localparam int TIMEOUT_DEF  = 4000;
    localparam int GAP_DEF      = 16;

    // Clamp a cycle limit into [1, 2**width-1] so it is always reachable
    // by a saturating counter of the given width.
    function automatic int clamp_limit(input int limit, input int width);
        int top;
        top = (1 << width) - 1;
        if (limit < 1) return 1;
        if (limit > top) return top;
        return limit;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input; clears to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so q takes the old meta, forming two stages rather than one.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/delay_meas_ctrl.sv
// Loop-delay measurement sequencer. Fires 2**AVG_LOG2 stimulus pulses on
// pulse_o, times each echo (synchronised echo_i) in clock cycles, accumulates
// the samples and publishes their truncated average on result_o with a
// one-cycle valid_o strobe. Any stuck echo line aborts the run and sets the
// sticky timeout_o flag.
// Optional feature: define DELAY_MEAS_MINMAX_EN to add min_o/max_o, the
// smallest and largest sample of the last completed run.
module delay_meas_ctrl
    import delay_meas_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int GAP      = GAP_DEF
) (
    input  logic             clk16M,
    input  logic             rstbt_n,
    input  logic             start_i,
    input  logic             echo_i,
    output logic             pulse_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] result_o,
    output logic             valid_o,
    output logic             timeout_o
`ifdef DELAY_MEAS_MINMAX_EN
    ,
    output logic [CNT_W-1:0] min_o,
    output logic [CNT_W-1:0] max_o
`endif
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int IDX_W = AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    // PULSE aborts when the counter reaches TIMEOUT (TIMEOUT+1 pulse cycles).
    localparam logic [CNT_W-1:0] TMO_LIM   = CNT_W'(clamp_limit(TIMEOUT, CNT_W));
    // ARM/RELEASE abort after TIMEOUT consecutive cycles of echo still high.
    localparam logic [CNT_W-1:0] WAIT_LIM  = CNT_W'(clamp_limit(TIMEOUT, CNT_W) - 1);
    localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(clamp_limit(GAP, CNT_W) - 1);
    localparam logic [IDX_W-1:0] N_SAMPLES = IDX_W'(2 ** AVG_LOG2);

    state_t             state_q;
    state_t             state_d;
    logic               echo_s;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [ACC_W-1:0]   acc_q;
    logic               accept;
    logic               capture;
    logic               abort;
    logic               gap_done;

    sync2 u_echo_sync (
        .clk   (clk16M),
        .rst_n (rstbt_n),
        .d     (echo_i),
        .q     (echo_s)
    );

    // Outputs decoded from the registered state so reset drops them at once.
    assign pulse_o  = (state_q == ST_PULSE);
    assign busy_o   = (state_q != ST_IDLE);
    assign valid_o  = (state_q == ST_DONE);
    assign accept   = (state_q == ST_IDLE) && start_i;
    assign gap_done = (cnt_q == GAP_LIM);

    // FSM state register.
    always_ff @(posedge clk16M or negedge rstbt_n) begin
        if (!rstbt_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic, sample capture and abort decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        capture = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!echo_s)                state_d = ST_PULSE;
                else if (cnt_q == WAIT_LIM) abort   = 1'b1;
            end
            ST_PULSE: begin
                // Echo takes priority over a timeout landing in the same cycle.
                if (echo_s) begin
                    capture = 1'b1;
                    state_d = ST_RELEASE;
                end else if (cnt_q == TMO_LIM) begin
                    abort = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!echo_s)                state_d = ST_GAPW;
                else if (cnt_q == WAIT_LIM) abort   = 1'b1;
            end
            ST_GAPW: begin
                if (gap_done)
                    state_d = (idx_q + 1'b1 == N_SAMPLES) ? ST_DONE : ST_PULSE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // Per-state cycle counter: cleared on every state change, saturating.
    // In PULSE it counts echo-low cycles; the echo-high cycle always leaves PULSE.
    always_ff @(posedge clk16M or negedge rstbt_n) begin
        if (!rstbt_n)                                    cnt_q <= '0;
        else if (state_d != state_q)                     cnt_q <= '0;
        else if (state_q != ST_IDLE && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
    end

    // Sample index and accumulator, restarted by each accepted start.
    always_ff @(posedge clk16M or negedge rstbt_n) begin
        if (!rstbt_n) begin
            idx_q <= '0;
            acc_q <= '0;
        end else if (accept) begin
            idx_q <= '0;
            acc_q <= '0;
        end else begin
            if (capture)                       acc_q <= acc_q + ACC_W'(cnt_q);
            if (state_q == ST_GAPW && gap_done) idx_q <= idx_q + 1'b1;
        end
    end

    // Published average (loaded on entry to DONE, aligned with valid_o) and sticky abort flag.
    always_ff @(posedge clk16M or negedge rstbt_n) begin
        if (!rstbt_n) begin
            result_o  <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (accept)     timeout_o <= 1'b0;
            else if (abort) timeout_o <= 1'b1;
            if (state_d == ST_DONE) result_o <= acc_q[ACC_W-1:AVG_LOG2];
        end
    end

`ifdef DELAY_MEAS_MINMAX_EN
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] max_q;

    // Running extremes of the current run's samples.
    always_ff @(posedge clk16M or negedge rstbt_n) begin
        if (!rstbt_n) begin
            min_q <= '1;
            max_q <= '0;
        end else if (accept) begin
            min_q <= '1;
            max_q <= '0;
        end else if (capture) begin
            if (cnt_q < min_q) min_q <= cnt_q;
            if (cnt_q > max_q) max_q <= cnt_q;
        end
    end

    // Extremes published together with result_o.
    always_ff @(posedge clk16M or negedge rstbt_n) begin
        if (!rstbt_n) begin
            min_o <= '0;
            max_o <= '0;
        end else if (state_d == ST_DONE) begin
            min_o <= min_q;
            max_o <= max_q;
        end
    end
`endif

endmodule
